// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      done;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port main memory between LSU, stack unit and fetch
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority 0 > 1 > 2 otherwise.
module mem_port_arbiter #(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [1:0]    idx;
    logic [AW-1:0] lat_addr;
    logic          lat_we;
    logic [DW-1:0] lat_wdata;
    logic [2:0]    gnt_q;
    logic [2:0]    done_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr;
    logic [1:0] c0, c1, c2;

    // Search starts just after the last granted requester, wrapping modulo 3.
    always_comb begin
        case (ptr)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (bus.req[c0])      win = c0;
        else if (bus.req[c1]) win = c1;
        else                  win = c2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 2'd2;
        else if (state == IDLE && |bus.req)
            ptr <= win;
    end
`else
    always_comb begin
        if (bus.req[0])      win = 2'd0;
        else if (bus.req[1]) win = 2'd1;
        else                 win = 2'd2;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            idx       <= 2'd0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            gnt_q     <= 3'b000;
            done_q    <= 3'b000;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 3'b000;
                    if (|bus.req) begin
                        idx       <= win;
                        lat_addr  <= bus.addr[int'(win)*AW +: AW];
                        lat_we    <= bus.we[win];
                        lat_wdata <= bus.wdata[int'(win)*DW +: DW];
                        gnt_q     <= 3'b001 << win;
                        cnt       <= CNT_INIT;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // mem_rdata is only valid on the final access cycle.
                        if (!lat_we)
                            rdata_q <= bus.mem_rdata;
                        gnt_q  <= 3'b000;
                        done_q <= 3'b001 << idx;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    done_q <= 3'b000;
                    state  <= IDLE;
                end
                default: begin
                    gnt_q  <= 3'b000;
                    done_q <= 3'b000;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes decode the state register so a reset drops them immediately.
    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && lat_we;
    assign bus.mem_addr  = (state == ACCESS) ? lat_addr : '0;
    assign bus.mem_wdata = (state == ACCESS) ? lat_wdata : '0;
    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter (LAT=2 and LAT=1 instances)
module tb_mem_port_arbiter;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LAT_A = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) ifa ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) ifb ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    logic [DW-1:0] mem [0:255];
    assign ifa.mem_rdata = mem[ifa.mem_addr];
    assign ifb.mem_rdata = mem[ifb.mem_addr];

    always @(posedge clk) begin
        if (ifa.mem_en && ifa.mem_we) mem[ifa.mem_addr] = ifa.mem_wdata;
        if (ifb.mem_en && ifb.mem_we) mem[ifb.mem_addr] = ifb.mem_wdata;
    end

    typedef struct {
        logic [2:0]    req;
        logic [2:0]    we;
        logic [AW-1:0] a0, a1, a2;
        logic [DW-1:0] d0, d1, d2;
        logic [2:0]    exp_done;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vt [8];
    int   nvec = 0;
    int   nbad = 0;

    function automatic vec_t mkv(input logic [2:0] req, input logic [2:0] we,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                 input logic [2:0] ed, input logic [DW-1:0] er);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.exp_done = ed; v.exp_rdata = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int            t, gcyc, wecyc, bad;
        logic [2:0]    d;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ea = v.exp_done[0] ? v.a0 : (v.exp_done[1] ? v.a1 : v.a2);
        ed = v.exp_done[0] ? v.d0 : (v.exp_done[1] ? v.d1 : v.d2);
        ifa.req   = v.req;
        ifa.we    = v.we;
        ifa.addr  = {v.a2, v.a1, v.a0};
        ifa.wdata = {v.d2, v.d1, v.d0};
        t = 0; gcyc = 0; wecyc = 0; bad = 0; d = 3'b000;
        while (d == 3'b000 && t < 10) begin
            @(negedge clk);
            t++;
            d = ifa.done;
            if (ifa.gnt == v.exp_done) gcyc++;
            if (ifa.mem_we) wecyc++;
            if (ifa.mem_en && ifa.mem_addr != ea) bad++;
            if (ifa.mem_we && ifa.mem_wdata != ed) bad++;
        end
        ifa.req = 3'b000;
        chk($sformatf("v%0d done", n), 32'(d), 32'(v.exp_done));
        chk($sformatf("v%0d latency", n), t, LAT_A + 1);
        chk($sformatf("v%0d gnt cycles", n), gcyc, LAT_A);
        chk($sformatf("v%0d mem_we cycles", n), wecyc, (|(v.we & v.exp_done)) ? LAT_A : 0);
        chk($sformatf("v%0d mem addr/wdata", n), bad, 0);
        chk($sformatf("v%0d rdata", n), 32'(ifa.rdata), 32'(v.exp_rdata));
        @(negedge clk);
        chk($sformatf("v%0d idle after", n), {ifa.busy, ifa.mem_en, ifa.gnt, ifa.done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] dl [6];
        int         tl [6];
        logic [2:0] exp6 [6];
        int         n, multi, dseen, busyc, enc, donec;
        logic [2:0] dval;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[5] = 16'h00AB;
        mem[3] = 16'h0042;

        ifa.req = '0; ifa.we = '0; ifa.addr = '0; ifa.wdata = '0;
        ifb.req = '0; ifb.we = '0; ifb.addr = '0; ifb.wdata = '0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
        vt[4] = mkv(3'b101, 3'b000, 8'd5, 8'd0, 8'd3, 16'h0, 16'h0, 16'h0, 3'b100, 16'h0042);
        exp6 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        vt[4] = mkv(3'b101, 3'b000, 8'd5, 8'd0, 8'd3, 16'h0, 16'h0, 16'h0, 3'b001, 16'h00AB);
        exp6 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        vt[0] = mkv(3'b100, 3'b000, 8'd0, 8'd0, 8'd5, 16'h0,    16'h0,    16'h0, 3'b100, 16'h00AB);
        vt[1] = mkv(3'b001, 3'b001, 8'd2, 8'd0, 8'd0, 16'h1234, 16'h0,    16'h0, 3'b001, 16'h00AB);
        vt[2] = mkv(3'b001, 3'b000, 8'd2, 8'd0, 8'd0, 16'h0,    16'h0,    16'h0, 3'b001, 16'h1234);
        vt[3] = mkv(3'b110, 3'b000, 8'd0, 8'd5, 8'd2, 16'h0,    16'h0,    16'h0, 3'b010, 16'h00AB);
        vt[5] = mkv(3'b011, 3'b010, 8'd3, 8'd9, 8'd0, 16'h0,    16'hBEEF, 16'h0, 3'b001, 16'h0042);
        vt[6] = mkv(3'b010, 3'b010, 8'd0, 8'd9, 8'd0, 16'h0,    16'hBEEF, 16'h0, 3'b010, 16'h0042);
        vt[7] = mkv(3'b100, 3'b000, 8'd0, 8'd0, 8'd9, 16'h0,    16'h0,    16'h0, 3'b100, 16'hBEEF);

        repeat (3) @(negedge clk);
        chk("reset gnt/done", {ifa.gnt, ifa.done}, 0);
        chk("reset rdata", 32'(ifa.rdata), 0);
        chk("reset mem strobes", {ifa.mem_en, ifa.mem_we}, 0);
        chk("reset mem_addr", 32'(ifa.mem_addr), 0);
        chk("reset mem_wdata", 32'(ifa.mem_wdata), 0);
        chk("reset busy", {ifa.busy, ifb.busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Contention: all three request, each drops its req on its own done.
        ifa.req = 3'b111; ifa.we = 3'b000;
        ifa.addr = {8'd2, 8'd3, 8'd5};
        n = 0; multi = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (!$onehot0(ifa.gnt) || !$onehot0(ifa.done)) multi++;
            if (ifa.done != 3'b000) begin
                dl[n] = ifa.done; tl[n] = c; n++;
                ifa.req = ifa.req & ~ifa.done;
            end
        end
        chk("contention count", n, 3);
        chk("contention order 0", 32'(dl[0]), 32'(3'b001));
        chk("contention order 1", 32'(dl[1]), 32'(3'b010));
        chk("contention order 2", 32'(dl[2]), 32'(3'b100));
        chk("contention spacing 1", tl[1] - tl[0], LAT_A + 2);
        chk("contention spacing 2", tl[2] - tl[1], LAT_A + 2);
        chk("contention multi-hot", multi, 0);
        chk("contention rdata", 32'(ifa.rdata), 32'h1234);
        @(negedge clk);

        // Held requests for six transactions.
        ifa.req = 3'b111;
        n = 0; multi = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (!$onehot0(ifa.gnt) || !$onehot0(ifa.done)) multi++;
            if (ifa.done != 3'b000) begin
                dl[n] = ifa.done; tl[n] = c; n++;
                if (n == 6) ifa.req = 3'b000;
            end
        end
        chk("held count", n, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("held order %0d", i), 32'(dl[i]), 32'(exp6[i]));
        chk("held spacing", tl[5] - tl[0], 5 * (LAT_A + 2));
        chk("held multi-hot", multi, 0);
        @(negedge clk);

        // Reset during the first access cycle of a write to addr 7.
        ifa.req = 3'b001; ifa.we = 3'b001;
        ifa.addr = {8'd0, 8'd0, 8'd7}; ifa.wdata = {16'h0, 16'h0, 16'h7777};
        @(posedge clk);
        #2;
        chk("mid-reset pre strobes", {ifa.mem_en, ifa.mem_we}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid-reset strobes", {ifa.mem_en, ifa.mem_we}, 0);
        chk("mid-reset busy/gnt", {ifa.busy, ifa.gnt}, 0);
        ifa.req = 3'b000; ifa.we = 3'b000;
        dseen = 0;
        repeat (2) begin
            @(negedge clk);
            if (ifa.done != 3'b000) dseen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ifa.done != 3'b000) dseen++;
        end
        chk("mid-reset no done", dseen, 0);
        chk("mid-reset idle", ifa.busy, 0);
        chk("mid-reset rdata", 32'(ifa.rdata), 0);
        chk("mid-reset mem[7]", 32'(mem[7]), 0);

        // LAT=1 instance: req1 pulsed for a single cycle.
        ifb.req = 3'b010; ifb.we = 3'b000;
        ifb.addr = {8'd0, 8'd3, 8'd0};
        busyc = 0; enc = 0; donec = 0; dval = 3'b000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ifb.busy) busyc++;
            if (ifb.mem_en) enc++;
            if (ifb.done != 3'b000) begin donec++; dval = ifb.done; end
            if (c == 0) ifb.req = 3'b000;
        end
        chk("lat1 busy cycles", busyc, 2);
        chk("lat1 access cycles", enc, 1);
        chk("lat1 done pulses", donec, 1);
        chk("lat1 done value", 32'(dval), 32'(3'b010));
        chk("lat1 rdata", 32'(ifb.rdata), 32'h0042);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
